rr_grant_encoder16: RTL and testbench

Round-robin request encoder: the inverse of the 4-to-16 one-hot select decoder in the processor datapath. It takes 16 request lines, chooses one winner per arbitration, and produces a registered 4-bit index plus a matching one-hot vector. The grant is held under a valid/ack handshake. It sits in front of shared resources (register-file write port, memory bus) where several pipeline agents compete and the consumer needs a binary select.

---
 rtl/rr_grant_encoder16.sv | 64 ++++++
 tb/tb_rr_grant_encoder16.sv | 117 +++++++++++
 2 files changed

// File: rtl/rr_grant_encoder16.sv
// rr_grant_encoder16: round-robin 16-way request arbiter.
// It presents a registered binary index and a one-hot grant, held under a valid/ack handshake.
module rr_grant_encoder16 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        grant_ack,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_onehot,
    output logic [3:0]  ptr
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d, idx_q, idx_d, start, off, win;
    logic [15:0] onehot_q, onehot_d, rot;
    logic        ack;
    assign ack   = (state_q == GRANT) && grant_ack;
    // On an ack the search already uses the advanced pointer, so the just-granted agent is searched last
    assign start = ack ? (ROUND_ROBIN ? idx_q + 4'd1 : 4'd0) : ptr_q;
    always_comb begin
        rot = 16'({req, req} >> start);
        off = 4'd0;
        for (int k = 15; k >= 0; k--)
            if (rot[k]) off = 4'(k);
        win = start + off;
    end
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        if (ack) ptr_d = start;
        if (state_q == IDLE || ack) begin
            if (|req) begin
                state_d  = GRANT;
                idx_d    = win;
                onehot_d = 16'd1 << win;
            end else begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end
    assign grant_valid  = (state_q == GRANT);
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;
    assign ptr          = ptr_q;
endmodule

// File: tb/tb_rr_grant_encoder16.sv
// tb_rr_grant_encoder16: directed vector table plus hand sequences for reset, wrap and fixed priority.
module tb_rr_grant_encoder16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req = '0;
    logic        grant_ack = 1'b0;
    logic        rr_valid, fp_valid;
    logic [3:0]  rr_idx, rr_ptr, fp_idx, fp_ptr;
    logic [15:0] rr_oh, fp_oh;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rr_grant_encoder16 #(.ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .grant_ack(grant_ack),
        .grant_valid(rr_valid), .grant_idx(rr_idx), .grant_onehot(rr_oh), .ptr(rr_ptr));

    rr_grant_encoder16 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .req(req), .grant_ack(grant_ack),
        .grant_valid(fp_valid), .grant_idx(fp_idx), .grant_onehot(fp_oh), .ptr(fp_ptr));

    typedef struct {
        logic [15:0] req;
        logic        ack;
        logic        valid;
        logic [3:0]  idx;
        logic [15:0] oh;
        logic [3:0]  ptr;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rr(input string tag, input logic v, input logic [3:0] i,
                            input logic [15:0] o, input logic [3:0] p);
        check({tag, ".valid"}, 16'(rr_valid), 16'(v));
        check({tag, ".idx"}, 16'(rr_idx), 16'(i));
        check({tag, ".onehot"}, rr_oh, o);
        check({tag, ".ptr"}, 16'(rr_ptr), 16'(p));
    endtask

    task automatic step(input logic [15:0] r, input logic a);
        req = r;
        grant_ack = a;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[22];

    initial begin
        vt[0]  = '{16'h0010, 1'b0, 1'b1, 4'd4,  16'h0010, 4'd1};
        vt[1]  = '{16'h0000, 1'b1, 1'b0, 4'd4,  16'h0000, 4'd5};
        vt[2]  = '{16'h0000, 1'b1, 1'b0, 4'd4,  16'h0000, 4'd5};
        vt[3]  = '{16'h0011, 1'b0, 1'b1, 4'd0,  16'h0001, 4'd5};
        vt[4]  = '{16'h0011, 1'b1, 1'b1, 4'd4,  16'h0010, 4'd1};
        vt[5]  = '{16'h0011, 1'b1, 1'b1, 4'd0,  16'h0001, 4'd5};
        vt[6]  = '{16'h0001, 1'b1, 1'b1, 4'd0,  16'h0001, 4'd1};
        vt[7]  = '{16'h0008, 1'b0, 1'b1, 4'd0,  16'h0001, 4'd1};
        vt[8]  = '{16'h0008, 1'b1, 1'b1, 4'd3,  16'h0008, 4'd1};
        for (int i = 9; i < 14; i++)
            vt[i] = '{16'h0000, 1'b0, 1'b1, 4'd3, 16'h0008, 4'd1};
        vt[14] = '{16'h0000, 1'b1, 1'b0, 4'd3,  16'h0000, 4'd4};
        vt[15] = '{16'hFFFF, 1'b0, 1'b1, 4'd4,  16'h0010, 4'd4};
        vt[16] = '{16'hFFFF, 1'b1, 1'b1, 4'd5,  16'h0020, 4'd5};
        vt[17] = '{16'h8001, 1'b1, 1'b1, 4'd15, 16'h8000, 4'd6};
        vt[18] = '{16'h8001, 1'b1, 1'b1, 4'd0,  16'h0001, 4'd0};
        vt[19] = '{16'h8001, 1'b1, 1'b1, 4'd15, 16'h8000, 4'd1};
        vt[20] = '{16'h8001, 1'b1, 1'b1, 4'd0,  16'h0001, 4'd0};
        vt[21] = '{16'h0200, 1'b1, 1'b1, 4'd9,  16'h0200, 4'd1};

        repeat (3) @(posedge clk);
        #1;
        check_rr("reset_hold", 1'b0, 4'd0, 16'h0000, 4'd0);
        reset = 1'b0;
        step(16'hFFFF, 1'b0);
        check_rr("first_grant", 1'b1, 4'd0, 16'h0001, 4'd0);
        step(16'hFFFF, 1'b1);
        check_rr("b2b_grant", 1'b1, 4'd1, 16'h0002, 4'd1);
        #2 reset = 1'b1;
        #1 check_rr("async_reset", 1'b0, 4'd0, 16'h0000, 4'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 check_rr("post_reset", 1'b1, 4'd0, 16'h0001, 4'd0);
        step(16'h0000, 1'b1);
        check_rr("drain", 1'b0, 4'd0, 16'h0000, 4'd1);

        for (int i = 0; i < 22; i++) begin
            step(vt[i].req, vt[i].ack);
            check_rr($sformatf("vec%0d", i), vt[i].valid, vt[i].idx, vt[i].oh, vt[i].ptr);
        end

        #2 reset = 1'b1;
        #1 check_rr("midgrant_reset", 1'b0, 4'd0, 16'h0000, 4'd0);
        check("fp_reset.valid", 16'(fp_valid), 16'd0);
        #1 reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step(16'h8001, 1'b1);
            check_rr($sformatf("wrap%0d", i), 1'b1, (i % 2 == 0) ? 4'd0 : 4'd15,
                     (i % 2 == 0) ? 16'h0001 : 16'h8000, (i % 2 == 0) ? 4'd0 : 4'd1);
            check($sformatf("fixed%0d.valid", i), 16'(fp_valid), 16'd1);
            check($sformatf("fixed%0d.idx", i), 16'(fp_idx), 16'd0);
            check($sformatf("fixed%0d.onehot", i), fp_oh, 16'h0001);
            check($sformatf("fixed%0d.ptr", i), 16'(fp_ptr), 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
